// File: rtl/mvu_pkg.sv
// mvu_pkg: shared MVU widths and the AGU state encoding.
package mvu_pkg;
  localparam int BDBANKA = 15;
  localparam int BLENGTH = 15;
  localparam int BCNTDWN = 29;
  localparam int NJUMPS = 5;
  typedef enum logic [1:0] {AGU_IDLE, AGU_RUN, AGU_FIN} agu_state_t;
endpackage

// File: rtl/mvu_agu_if.sv
// mvu_agu_if: job config, stall and address stream of one AGU; tick exists only with MVU_AGU_LOOPTICK_EN.
interface mvu_agu_if #(
  parameter int BADDR = mvu_pkg::BDBANKA,
  parameter int BLENGTH = mvu_pkg::BLENGTH,
  parameter int BCNTDWN = mvu_pkg::BCNTDWN,
  parameter int NJUMPS = mvu_pkg::NJUMPS
) ();
  logic start;
  logic [BCNTDWN-1:0] countdown;
  logic [BADDR-1:0] baseaddr;
  logic [NJUMPS*BADDR-1:0] jump;
  logic [(NJUMPS-1)*BLENGTH-1:0] length;
  logic stall;
  logic [BADDR-1:0] addr;
  logic addr_valid;
  logic busy;
  logic done;
`ifdef MVU_AGU_LOOPTICK_EN
  logic [NJUMPS-1:0] tick;
  modport master (output start, countdown, baseaddr, jump, length, stall,
                  input addr, addr_valid, busy, done, tick);
  modport slave (input start, countdown, baseaddr, jump, length, stall,
                 output addr, addr_valid, busy, done, tick);
`else
  modport master (output start, countdown, baseaddr, jump, length, stall,
                  input addr, addr_valid, busy, done);
  modport slave (input start, countdown, baseaddr, jump, length, stall,
                 output addr, addr_valid, busy, done);
`endif
endinterface

// File: rtl/mvu_agu_lvlsel.sv
// mvu_agu_lvlsel: one-hot pick of the lowest level with a nonzero counter; top bit when none.
module mvu_agu_lvlsel #(
  parameter int N = mvu_pkg::NJUMPS
) (
  input  logic [N-2:0] nz,
  output logic [N-1:0] sel
);
  logic [N-1:0] r;
  assign r = {1'b1, nz};
  assign sel = r & (~r + N'(1));
endmodule

// File: rtl/mvu_agu.sv
// mvu_agu: nested-loop data-bank address generator; MVU_AGU_LOOPTICK_EN adds the per-level tick output.
module mvu_agu #(
  parameter int BADDR = mvu_pkg::BDBANKA,
  parameter int BLENGTH = mvu_pkg::BLENGTH,
  parameter int BCNTDWN = mvu_pkg::BCNTDWN,
  parameter int NJUMPS = mvu_pkg::NJUMPS
) (
  input logic clk,
  input logic rst,
  mvu_agu_if.slave bus
);
  import mvu_pkg::*;
  agu_state_t state, state_nxt;
  logic [BADDR-1:0] addr_q, step;
  logic [BCNTDWN-1:0] cnt;
  logic [NJUMPS-2:0][BLENGTH-1:0] lvl_cnt, lvl_nxt, len;
  logic [NJUMPS-1:0][BADDR-1:0] jmp;
  logic [NJUMPS-2:0] nz, rl;
  logic [NJUMPS-1:0] sel;
  logic load, advance, last;
  assign len = bus.length;
  assign jmp = bus.jump;
  assign load = state == AGU_IDLE && bus.start && bus.countdown != '0;
  assign advance = state == AGU_RUN && !bus.stall;
  assign last = cnt == BCNTDWN'(1);
  mvu_agu_lvlsel #(.N(NJUMPS)) u_lvlsel (.nz(nz), .sel(sel));
  always_comb begin
    step = '0;
    for (int i = 0; i < NJUMPS; i++) step = step | (sel[i] ? jmp[i] : '0);
    for (int i = 0; i < NJUMPS-1; i++) begin
      nz[i] = lvl_cnt[i] != '0;
      rl[i] = (sel >> (i+1)) != '0;
      lvl_nxt[i] = sel[i] ? lvl_cnt[i] - BLENGTH'(1) : rl[i] ? len[i] : lvl_cnt[i];
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == AGU_IDLE && bus.start) state_nxt = bus.countdown != '0 ? AGU_RUN : AGU_FIN;
    else if (advance && last) state_nxt = AGU_FIN;
    else if (state == AGU_FIN) state_nxt = AGU_IDLE;
    bus.addr = addr_q;
    bus.addr_valid = state == AGU_RUN;
    bus.busy = state == AGU_RUN;
    bus.done = state == AGU_FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AGU_IDLE;
      addr_q <= '0;
      cnt <= '0;
      lvl_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        addr_q <= bus.baseaddr;
        cnt <= bus.countdown;
        lvl_cnt <= len;
      end else if (advance) begin
        cnt <= cnt - BCNTDWN'(1);
        if (!last) begin
          addr_q <= addr_q + step;
          lvl_cnt <= lvl_nxt;
        end
      end
    end
  end
`ifdef MVU_AGU_LOOPTICK_EN
  logic [NJUMPS-1:0] tick_q, tick_nxt;
  // An outermost step marks the level just above the highest loop with a nonzero length.
  always_comb begin
    int top;
    top = NJUMPS-1;
    for (int i = 0; i < NJUMPS-1; i++) if (len[i] != '0) top = i+1;
    tick_nxt = sel[NJUMPS-1] ? NJUMPS'(1) << top : sel;
  end
  always_ff @(posedge clk) begin
    if (rst || load) tick_q <= '0;
    else if (advance) tick_q <= last ? '0 : tick_nxt;
  end
  assign bus.tick = tick_q;
`endif
endmodule
